// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, accepts out-of-order completions, retires in order.
// Latency: completion becomes visible at the next edge; the head commits combinationally once completed.
// Backpressure: alloc_ready_o drops while full; commit has no stall, and a flushing commit discards the buffer.
module reorder_buffer #(
  parameter int ROB_SIZE     = 16,
  parameter int ROB_IDX_BITS = $clog2(ROB_SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    alloc_valid_i,
  input  logic [31:0]             alloc_pc_i,
  input  logic [31:0]             alloc_instr_i,
  input  logic [4:0]              alloc_rd_i,
  input  logic                    alloc_we_i,
  input  logic                    alloc_store_i,
  input  logic [31:0]             alloc_kanata_id_i,
  output logic                    alloc_ready_o,
  output logic [ROB_IDX_BITS-1:0] alloc_idx_o,
  input  logic                    cmpl_valid_i,
  input  logic [ROB_IDX_BITS-1:0] cmpl_idx_i,
  input  logic [31:0]             cmpl_result_i,
  input  logic [31:0]             cmpl_new_pc_i,
  input  logic                    cmpl_branch_taken_i,
  input  logic                    cmpl_xcpt_i,
  input  logic [5:0]              cmpl_xcpt_code_i,
  output logic                    commit_valid_o,
  output logic [ROB_IDX_BITS-1:0] commit_idx_o,
  output logic [31:0]             commit_pc_o,
  output logic [31:0]             commit_instr_o,
  output logic [4:0]              commit_rd_o,
  output logic                    commit_we_o,
  output logic                    commit_store_o,
  output logic [31:0]             commit_result_o,
  output logic [31:0]             commit_kanata_id_o,
  output logic                    flush_o,
  output logic [31:0]             flush_pc_o,
  output logic                    empty_o,
  output logic                    full_o
);

  localparam logic [31:0] ADDR_XCPT = 32'h0000_2000;
  localparam int          CNT_BITS  = ROB_IDX_BITS + 1;

  typedef struct packed {
    logic        valid;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic        store;
    logic [31:0] result;
    logic [31:0] new_pc;
    logic        branch_taken;
    logic [31:0] kanata_id;
    logic        xcpt;
    logic [5:0]  xcpt_code;
  } rob_entry_t;

  rob_entry_t              entry_q [ROB_SIZE];
  rob_entry_t              entry_d [ROB_SIZE];
  logic [ROB_IDX_BITS-1:0] head_q, head_d;
  logic [ROB_IDX_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0]     count_q, count_d;

  rob_entry_t head_e;
  logic       alloc_fire;
  logic       cmpl_fire;
  logic       commit_fire;
  logic       flush;

  assign head_e        = entry_q[head_q];
  assign full_o        = (count_q == CNT_BITS'(ROB_SIZE));
  assign empty_o       = (count_q == '0);
  assign alloc_ready_o = !full_o;
  assign alloc_idx_o   = tail_q;

  assign alloc_fire  = alloc_valid_i && !full_o;
  assign cmpl_fire   = cmpl_valid_i && entry_q[cmpl_idx_i].valid;
  // A completion lands at the next edge, so the head can never complete and commit in one cycle.
  assign commit_fire = head_e.valid && head_e.completed;
  assign flush       = commit_fire && (head_e.xcpt || head_e.branch_taken);

  assign commit_valid_o = commit_fire;
  assign flush_o        = flush;

  // Commit data outputs: zero unless the head retires; exceptions suppress architectural writes.
  always_comb begin
    commit_idx_o       = '0;
    commit_pc_o        = '0;
    commit_instr_o     = '0;
    commit_rd_o        = '0;
    commit_we_o        = 1'b0;
    commit_store_o     = 1'b0;
    commit_result_o    = '0;
    commit_kanata_id_o = '0;
    flush_pc_o         = '0;
    if (commit_fire) begin
      commit_idx_o       = head_q;
      commit_pc_o        = head_e.pc;
      commit_instr_o     = head_e.instr;
      commit_rd_o        = head_e.rd;
      commit_we_o        = head_e.we && !head_e.xcpt;
      commit_store_o     = head_e.store && !head_e.xcpt;
      commit_result_o    = head_e.result;
      commit_kanata_id_o = head_e.kanata_id;
      if (head_e.xcpt) begin
        flush_pc_o = ADDR_XCPT;
      end else if (head_e.branch_taken) begin
        flush_pc_o = head_e.new_pc;
      end
    end
  end

  // Next-state: a flush wipes everything and swallows same-cycle alloc/completion.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_d[i].valid     = 1'b0;
        entry_d[i].completed = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cmpl_fire) begin
        entry_d[cmpl_idx_i].completed    = 1'b1;
        entry_d[cmpl_idx_i].result       = cmpl_result_i;
        entry_d[cmpl_idx_i].new_pc       = cmpl_new_pc_i;
        entry_d[cmpl_idx_i].branch_taken = cmpl_branch_taken_i;
        entry_d[cmpl_idx_i].xcpt         = cmpl_xcpt_i;
        entry_d[cmpl_idx_i].xcpt_code    = cmpl_xcpt_code_i;
      end
      if (commit_fire) begin
        entry_d[head_q].valid     = 1'b0;
        entry_d[head_q].completed = 1'b0;
        head_d                    = head_q + ROB_IDX_BITS'(1);
      end
      // Allocation can never alias the head here: when tail==head with entries live, the buffer is full.
      if (alloc_fire) begin
        entry_d[tail_q]           = '0;
        entry_d[tail_q].valid     = 1'b1;
        entry_d[tail_q].pc        = alloc_pc_i;
        entry_d[tail_q].instr     = alloc_instr_i;
        entry_d[tail_q].rd        = alloc_rd_i;
        entry_d[tail_q].we        = alloc_we_i;
        entry_d[tail_q].store     = alloc_store_i;
        entry_d[tail_q].kanata_id = alloc_kanata_id_i;
        tail_d                    = tail_q + ROB_IDX_BITS'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table, directed corner sequences, random vs queue model.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later, well before the next edge.
// A watchdog bounds the run so it always reaches an end.
module tb_reorder_buffer;
  localparam int N = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic [31:0] alloc_pc_i;
  logic [31:0] alloc_instr_i;
  logic [4:0]  alloc_rd_i;
  logic        alloc_we_i;
  logic        alloc_store_i;
  logic [31:0] alloc_kanata_id_i;
  logic        alloc_ready_o;
  logic [3:0]  alloc_idx_o;
  logic        cmpl_valid_i;
  logic [3:0]  cmpl_idx_i;
  logic [31:0] cmpl_result_i;
  logic [31:0] cmpl_new_pc_i;
  logic        cmpl_branch_taken_i;
  logic        cmpl_xcpt_i;
  logic [5:0]  cmpl_xcpt_code_i;
  logic        commit_valid_o;
  logic [3:0]  commit_idx_o;
  logic [31:0] commit_pc_o;
  logic [31:0] commit_instr_o;
  logic [4:0]  commit_rd_o;
  logic        commit_we_o;
  logic        commit_store_o;
  logic [31:0] commit_result_o;
  logic [31:0] commit_kanata_id_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic        empty_o;
  logic        full_o;

  always #5 clk_i = ~clk_i;

  reorder_buffer #(.ROB_SIZE(N), .ROB_IDX_BITS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_instr_i(alloc_instr_i),
    .alloc_rd_i(alloc_rd_i), .alloc_we_i(alloc_we_i), .alloc_store_i(alloc_store_i),
    .alloc_kanata_id_i(alloc_kanata_id_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_idx_i(cmpl_idx_i), .cmpl_result_i(cmpl_result_i),
    .cmpl_new_pc_i(cmpl_new_pc_i), .cmpl_branch_taken_i(cmpl_branch_taken_i),
    .cmpl_xcpt_i(cmpl_xcpt_i), .cmpl_xcpt_code_i(cmpl_xcpt_code_i),
    .commit_valid_o(commit_valid_o), .commit_idx_o(commit_idx_o), .commit_pc_o(commit_pc_o),
    .commit_instr_o(commit_instr_o), .commit_rd_o(commit_rd_o), .commit_we_o(commit_we_o),
    .commit_store_o(commit_store_o), .commit_result_o(commit_result_o),
    .commit_kanata_id_o(commit_kanata_id_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_instr_i = '0; alloc_rd_i = '0;
    alloc_we_i = 1'b0; alloc_store_i = 1'b0; alloc_kanata_id_i = '0;
    cmpl_valid_i = 1'b0; cmpl_idx_i = '0; cmpl_result_i = '0; cmpl_new_pc_i = '0;
    cmpl_branch_taken_i = 1'b0; cmpl_xcpt_i = 1'b0; cmpl_xcpt_code_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid_i = 1'b1;
      alloc_pc_i    = 32'(4 * i);
      alloc_we_i    = 1'b1;
      tick();
    end
    alloc_valid_i = 1'b0;
  endtask

  task automatic cmpl(input logic [3:0] idx, input logic [31:0] res, input logic tk,
                      input logic [31:0] npc, input logic xc);
    cmpl_valid_i = 1'b1; cmpl_idx_i = idx; cmpl_result_i = res;
    cmpl_branch_taken_i = tk; cmpl_new_pc_i = npc; cmpl_xcpt_i = xc;
    tick();
    cmpl_valid_i = 1'b0; cmpl_branch_taken_i = 1'b0; cmpl_xcpt_i = 1'b0;
  endtask

  // ---------------- reference model: in-order queue of live instructions ----------------
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] pc, instr, kid, res, npc;
    logic [4:0]  rd;
    logic        we, st, done, tk, xc;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail;

  task automatic check_model();
    m_ent_t      h;
    logic        c;
    logic [31:0] fpc;
    c = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      c = h.done;
    end
    fpc = '0;
    if (c && h.xc) fpc = 32'h0000_2000;
    else if (c && h.tk) fpc = h.npc;
    chk("rand_alloc_ready", 32'(alloc_ready_o), 32'(mq.size() != N));
    chk("rand_alloc_idx", 32'(alloc_idx_o), 32'(m_tail));
    chk("rand_empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("rand_full", 32'(full_o), 32'(mq.size() == N));
    chk("rand_commit_valid", 32'(commit_valid_o), 32'(c));
    chk("rand_commit_idx", 32'(commit_idx_o), c ? 32'(h.idx) : 32'h0);
    chk("rand_commit_pc", commit_pc_o, c ? h.pc : 32'h0);
    chk("rand_commit_instr", commit_instr_o, c ? h.instr : 32'h0);
    chk("rand_commit_rd", 32'(commit_rd_o), c ? 32'(h.rd) : 32'h0);
    chk("rand_commit_we", 32'(commit_we_o), 32'(c && h.we && !h.xc));
    chk("rand_commit_store", 32'(commit_store_o), 32'(c && h.st && !h.xc));
    chk("rand_commit_result", commit_result_o, c ? h.res : 32'h0);
    chk("rand_commit_kid", commit_kanata_id_o, c ? h.kid : 32'h0);
    chk("rand_flush", 32'(flush_o), 32'(c && (h.xc || h.tk)));
    chk("rand_flush_pc", flush_pc_o, fpc);
  endtask

  task automatic model_step();
    logic   c, fl, was_full;
    m_ent_t e;
    c  = (mq.size() > 0) && mq[0].done;
    fl = c && (mq[0].xc || mq[0].tk);
    was_full = (mq.size() == N);
    if (fl) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (cmpl_valid_i) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].idx == cmpl_idx_i) begin
            e = mq[k];
            e.done = 1'b1; e.res = cmpl_result_i; e.npc = cmpl_new_pc_i;
            e.tk = cmpl_branch_taken_i; e.xc = cmpl_xcpt_i;
            mq[k] = e;
          end
        end
      end
      if (c) void'(mq.pop_front());
      if (alloc_valid_i && !was_full) begin
        e.idx = 4'(m_tail); e.pc = alloc_pc_i; e.instr = alloc_instr_i; e.rd = alloc_rd_i;
        e.we = alloc_we_i; e.st = alloc_store_i; e.kid = alloc_kanata_id_i;
        e.done = 1'b0; e.res = '0; e.npc = '0; e.tk = 1'b0; e.xc = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        av;
    logic [31:0] apc;
    logic        awe;
    logic        cv;
    logic [3:0]  cidx;
    logic [31:0] cres;
    logic        cxc;
    logic [3:0]  e_aidx;
    logic        e_cv;
    logic [3:0]  e_cidx;
    logic [31:0] e_res;
    logic        e_we;
    logic        e_fl;
    logic [31:0] e_fpc;
    logic        e_empty;
  } vec_t;

  vec_t tv [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    idle();
    rst_i = 1'b1;
    #12;
    chk("rst_alloc_ready", 32'(alloc_ready_o), 32'h1);
    chk("rst_alloc_idx", 32'(alloc_idx_o), 32'h0);
    chk("rst_commit_valid", 32'(commit_valid_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_empty", 32'(empty_o), 32'h1);
    chk("rst_full", 32'(full_o), 32'h0);
    rst_i = 1'b0;
    tick();

    // Three allocations completed out of order (2,0,1), then an exception commit.
    //          av    apc          awe   cv    cidx   cres   cxc   aidx  cv    cidx   res    we    fl    fpc           empty
    tv[0]  = '{1'b1, 32'h0,       1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1};
    tv[1]  = '{1'b1, 32'h4,       1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[2]  = '{1'b1, 32'h8,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[3]  = '{1'b0, 32'h0,       1'b0, 1'b1, 4'd2, 32'hA, 1'b0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[4]  = '{1'b0, 32'h0,       1'b0, 1'b1, 4'd0, 32'hB, 1'b0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[5]  = '{1'b0, 32'h0,       1'b0, 1'b1, 4'd1, 32'hC, 1'b0, 4'd3, 1'b1, 4'd0, 32'hB, 1'b1, 1'b0, 32'h0,       1'b0};
    tv[6]  = '{1'b0, 32'h0,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 1'b1, 4'd1, 32'hC, 1'b1, 1'b0, 32'h0,       1'b0};
    tv[7]  = '{1'b0, 32'h0,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 1'b1, 4'd2, 32'hA, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[8]  = '{1'b0, 32'h0,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1};
    tv[9]  = '{1'b1, 32'h20,      1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1};
    tv[10] = '{1'b0, 32'h0,       1'b0, 1'b1, 4'd3, 32'h0, 1'b1, 4'd4, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b0};
    tv[11] = '{1'b0, 32'h0,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd4, 1'b1, 4'd3, 32'h0, 1'b0, 1'b1, 32'h2000,    1'b0};
    tv[12] = '{1'b0, 32'h0,       1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1};

    for (int r = 0; r < 13; r++) begin
      idle();
      alloc_valid_i = tv[r].av; alloc_pc_i = tv[r].apc; alloc_we_i = tv[r].awe; alloc_rd_i = 5'd5;
      cmpl_valid_i = tv[r].cv; cmpl_idx_i = tv[r].cidx; cmpl_result_i = tv[r].cres;
      cmpl_xcpt_i = tv[r].cxc; cmpl_xcpt_code_i = tv[r].cxc ? 6'd2 : 6'd0;
      #1;
      chk($sformatf("vec%0d_alloc_idx", r), 32'(alloc_idx_o), 32'(tv[r].e_aidx));
      chk($sformatf("vec%0d_commit_valid", r), 32'(commit_valid_o), 32'(tv[r].e_cv));
      chk($sformatf("vec%0d_commit_idx", r), 32'(commit_idx_o), 32'(tv[r].e_cidx));
      chk($sformatf("vec%0d_commit_result", r), commit_result_o, tv[r].e_res);
      chk($sformatf("vec%0d_commit_we", r), 32'(commit_we_o), 32'(tv[r].e_we));
      chk($sformatf("vec%0d_flush", r), 32'(flush_o), 32'(tv[r].e_fl));
      chk($sformatf("vec%0d_flush_pc", r), flush_pc_o, tv[r].e_fpc);
      chk($sformatf("vec%0d_empty", r), 32'(empty_o), 32'(tv[r].e_empty));
      tick();
    end
    idle();

    // Fill to full, refused 17th request, commit while full with alloc held, then wrap.
    do_reset();
    for (int i = 0; i < N; i++) begin
      alloc_valid_i = 1'b1; alloc_pc_i = 32'(4 * i);
      #1;
      chk("fill_alloc_idx", 32'(alloc_idx_o), 32'(i));
      tick();
    end
    chk("full_full", 32'(full_o), 32'h1);
    chk("full_ready", 32'(alloc_ready_o), 32'h0);
    tick();
    chk("full_17th_idx", 32'(alloc_idx_o), 32'h0);
    chk("full_17th_full", 32'(full_o), 32'h1);
    cmpl(4'd0, 32'h77, 1'b0, 32'h0, 1'b0);
    chk("full_commit_valid", 32'(commit_valid_o), 32'h1);
    chk("full_commit_idx", 32'(commit_idx_o), 32'h0);
    chk("full_commit_ready", 32'(alloc_ready_o), 32'h0);
    tick();
    chk("after_commit_full", 32'(full_o), 32'h0);
    chk("after_commit_ready", 32'(alloc_ready_o), 32'h1);
    chk("after_commit_wrap_idx", 32'(alloc_idx_o), 32'h0);
    chk("after_commit_empty", 32'(empty_o), 32'h0);
    tick();
    chk("refill_full", 32'(full_o), 32'h1);
    chk("refill_idx", 32'(alloc_idx_o), 32'h1);
    idle();

    // Taken branch at idx 1 while younger entries already completed.
    do_reset();
    alloc_n(5);
    cmpl(4'd2, 32'h2, 1'b0, 32'h0, 1'b0);
    cmpl(4'd3, 32'h3, 1'b0, 32'h0, 1'b0);
    cmpl(4'd4, 32'h4, 1'b0, 32'h0, 1'b0);
    cmpl(4'd1, 32'h1, 1'b1, 32'h100, 1'b0);
    cmpl(4'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("br_c0_valid", 32'(commit_valid_o), 32'h1);
    chk("br_c0_idx", 32'(commit_idx_o), 32'h0);
    chk("br_c0_flush", 32'(flush_o), 32'h0);
    tick();
    chk("br_c1_valid", 32'(commit_valid_o), 32'h1);
    chk("br_c1_idx", 32'(commit_idx_o), 32'h1);
    chk("br_c1_flush", 32'(flush_o), 32'h1);
    chk("br_c1_flush_pc", flush_pc_o, 32'h100);
    tick();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (commit_valid_o) extra++;
      tick();
    end
    chk("br_no_more_commits", 32'(extra), 32'h0);
    chk("br_empty", 32'(empty_o), 32'h1);
    chk("br_next_idx", 32'(alloc_idx_o), 32'h0);

    // Asynchronous reset mid-operation with a committable head.
    do_reset();
    alloc_n(5);
    cmpl(4'd0, 32'h9, 1'b0, 32'h0, 1'b0);
    chk("arst_pre_commit_valid", 32'(commit_valid_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_empty", 32'(empty_o), 32'h1);
    chk("arst_full", 32'(full_o), 32'h0);
    chk("arst_ready", 32'(alloc_ready_o), 32'h1);
    chk("arst_idx", 32'(alloc_idx_o), 32'h0);
    chk("arst_commit_valid", 32'(commit_valid_o), 32'h0);
    chk("arst_flush", 32'(flush_o), 32'h0);
    rst_i = 1'b0;
    tick();
    chk("arst_post_empty", 32'(empty_o), 32'h1);
    alloc_valid_i = 1'b1;
    #1;
    chk("arst_first_idx", 32'(alloc_idx_o), 32'h0);
    tick();
    alloc_valid_i = 1'b0;
    chk("arst_second_idx", 32'(alloc_idx_o), 32'h1);

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    m_tail = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      alloc_valid_i       = ($urandom_range(0, 9) < 7);
      alloc_pc_i          = $urandom;
      alloc_instr_i       = $urandom;
      alloc_rd_i          = 5'($urandom);
      alloc_we_i          = 1'($urandom);
      alloc_store_i       = 1'($urandom);
      alloc_kanata_id_i   = $urandom;
      cmpl_valid_i        = ($urandom_range(0, 9) < 5);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0)
        cmpl_idx_i = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        cmpl_idx_i = 4'($urandom);
      cmpl_result_i       = $urandom;
      cmpl_new_pc_i       = $urandom;
      cmpl_branch_taken_i = ($urandom_range(0, 15) == 0);
      cmpl_xcpt_i         = ($urandom_range(0, 31) == 0);
      cmpl_xcpt_code_i    = 6'($urandom);
      #1;
      check_model();
      model_step();
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
